// File: rtl/pipe_pkg.sv
// Shared types for the LEGv8 memory stage.
//   ex_mem_t    : control fields of the EX/MEM pipeline register
//   mem_wb_t    : control fields of the MEM/WB pipeline register
//   mem_state_e : data-memory access FSM states
// The DW-wide data fields sit next to these structs as separate registers,
// so the structs do not depend on the data width parameter.
package pipe_pkg;

  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic            valid;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic            regWrite;
    logic            memToReg;
    logic            zero;
    logic [RD_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic            regWrite;
    logic            memToReg;
    logic [RD_W-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller for the memory stage.
// Runs one req/ack transaction for each memory instruction in EX/MEM, captures
// the read data, and flags a sticky bus error on timeout.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   mem_op_i   EX/MEM holds a valid load/store
//   ack_i      memory accepted the request / read data valid
//   rdata_i    read data, valid with ack_i
//   req_o      memory request (high exactly while in REQ)
//   done_o     access finished this cycle (releases the stall)
//   bus_err_o  sticky timeout flag, cleared only by reset
//   rdata_o    last captured read data
module dmem_ctrl
  import pipe_pkg::*;
#(
  parameter int DW      = 64,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          mem_op_i,
  input  logic          ack_i,
  input  logic [DW-1:0] rdata_i,
  output logic          req_o,
  output logic          done_o,
  output logic          bus_err_o,
  output logic [DW-1:0] rdata_o
);

  // TIMEOUT=0 disables the timeout; the counter still needs at least one bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op_i) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle still completes the access.
        if (ack_i) begin
          state_d = DONE;
          rdata_d = rdata_i;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_C) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign req_o     = (state_q == REQ);
  assign done_o    = (state_q == DONE);
  assign bus_err_o = err_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage LEGv8 pipeline.
// Holds the EX/MEM register, resolves conditional branches, runs LDUR/STUR
// through dmem_ctrl and produces the MEM/WB register. While a memory access
// is in flight stall_M freezes everything upstream and MEM/WB takes bubbles.
// Ports:
//   clk, reset (async, active-low)
//   ex_*           control from execute; PCBranch_E/aluResult_E/writeData_E/zero_E data
//   stall_M        hold PC, IF/ID, ID/EX, EX/MEM
//   PCSrc_M        take branch; PCBranch_M registered target
//   dm_req/dm_we/dm_addr/dm_wdata, dm_ack/dm_rdata   data memory handshake
//   bus_err        sticky access timeout
//   wb_*           MEM/WB register outputs
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DW      = 64,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_memRead,
  input  logic            ex_memWrite,
  input  logic            ex_branch,
  input  logic            ex_regWrite,
  input  logic            ex_memToReg,
  input  logic [RD_W-1:0] ex_rd,
  input  logic [DW-1:0]   PCBranch_E,
  input  logic [DW-1:0]   aluResult_E,
  input  logic [DW-1:0]   writeData_E,
  input  logic            zero_E,
  output logic            stall_M,
  output logic            PCSrc_M,
  output logic [DW-1:0]   PCBranch_M,
  output logic            dm_req,
  output logic            dm_we,
  output logic [DW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_wdata,
  input  logic            dm_ack,
  input  logic [DW-1:0]   dm_rdata,
  output logic            bus_err,
  output logic            wb_valid,
  output logic            wb_regWrite,
  output logic            wb_memToReg,
  output logic [RD_W-1:0] wb_rd,
  output logic [DW-1:0]   wb_aluResult,
  output logic [DW-1:0]   wb_readData
);

  ex_mem_t       m_q, m_d;
  logic [DW-1:0] m_pcBranch_q, m_aluResult_q, m_writeData_q;
  mem_wb_t       wb_q;
  logic [DW-1:0] wb_aluResult_q, wb_readData_q;

  logic          m_mem;
  logic          mem_done;
  logic [DW-1:0] rdata;

  always_comb begin
    m_d          = '0;
    m_d.valid    = ex_valid;
    m_d.memRead  = ex_memRead;
    m_d.memWrite = ex_memWrite;
    m_d.branch   = ex_branch;
    m_d.regWrite = ex_regWrite;
    m_d.memToReg = ex_memToReg;
    m_d.zero     = zero_E;
    m_d.rd       = ex_rd;
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q           <= '0;
      m_pcBranch_q  <= '0;
      m_aluResult_q <= '0;
      m_writeData_q <= '0;
    end else if (!stall_M) begin
      m_q           <= m_d;
      m_pcBranch_q  <= PCBranch_E;
      m_aluResult_q <= aluResult_E;
      m_writeData_q <= writeData_E;
    end
  end

  assign m_mem   = m_q.valid & (m_q.memRead | m_q.memWrite);
  // The stall drops in DONE so the finished access leaves M on the next edge.
  assign stall_M = m_mem & ~mem_done;

  assign PCSrc_M    = m_q.valid & m_q.branch & m_q.zero;
  assign PCBranch_M = m_pcBranch_q;

  // Write wins when both memRead and memWrite are set.
  assign dm_we    = m_q.memWrite;
  assign dm_addr  = m_aluResult_q;
  assign dm_wdata = m_writeData_q;

  dmem_ctrl #(
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) u_dmem_ctrl (
    .clk_i     (clk),
    .rst_ni    (reset),
    .mem_op_i  (m_mem),
    .ack_i     (dm_ack),
    .rdata_i   (dm_rdata),
    .req_o     (dm_req),
    .done_o    (mem_done),
    .bus_err_o (bus_err),
    .rdata_o   (rdata)
  );

  // MEM/WB register; a stalled cycle inserts a bubble and holds the payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q           <= '0;
      wb_aluResult_q <= '0;
      wb_readData_q  <= '0;
    end else if (stall_M) begin
      wb_q.valid <= 1'b0;
    end else begin
      wb_q.valid     <= m_q.valid;
      wb_q.regWrite  <= m_q.regWrite;
      wb_q.memToReg  <= m_q.memToReg;
      wb_q.rd        <= m_q.rd;
      wb_aluResult_q <= m_aluResult_q;
      wb_readData_q  <= rdata;
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_regWrite  = wb_q.regWrite;
  assign wb_memToReg  = wb_q.memToReg;
  assign wb_rd        = wb_q.rd;
  assign wb_aluResult = wb_aluResult_q;
  assign wb_readData  = wb_readData_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic          ex_valid, ex_memRead, ex_memWrite, ex_branch, ex_regWrite, ex_memToReg;
  logic [4:0]    ex_rd;
  logic [DW-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic          zero_E;
  logic          stall_M, PCSrc_M;
  logic [DW-1:0] PCBranch_M;
  logic          dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          bus_err;
  logic          wb_valid, wb_regWrite, wb_memToReg;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_aluResult, wb_readData;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DW(DW), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_memRead   (ex_memRead),
    .ex_memWrite  (ex_memWrite),
    .ex_branch    (ex_branch),
    .ex_regWrite  (ex_regWrite),
    .ex_memToReg  (ex_memToReg),
    .ex_rd        (ex_rd),
    .PCBranch_E   (PCBranch_E),
    .aluResult_E  (aluResult_E),
    .writeData_E  (writeData_E),
    .zero_E       (zero_E),
    .stall_M      (stall_M),
    .PCSrc_M      (PCSrc_M),
    .PCBranch_M   (PCBranch_M),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .bus_err      (bus_err),
    .wb_valid     (wb_valid),
    .wb_regWrite  (wb_regWrite),
    .wb_memToReg  (wb_memToReg),
    .wb_rd        (wb_rd),
    .wb_aluResult (wb_aluResult),
    .wb_readData  (wb_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic v, input logic rd_, input logic wr_, input logic br_,
                          input logic rw_, input logic m2r_, input logic [4:0] rdn,
                          input logic [63:0] pcb, input logic [63:0] alu,
                          input logic [63:0] wd, input logic z);
    ex_valid    = v;
    ex_memRead  = rd_;
    ex_memWrite = wr_;
    ex_branch   = br_;
    ex_regWrite = rw_;
    ex_memToReg = m2r_;
    ex_rd       = rdn;
    PCBranch_E  = pcb;
    aluResult_E = alu;
    writeData_E = wd;
    zero_E      = z;
  endtask

  task automatic bubble();
    drive_ex(0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0);
  endtask

  initial begin
    reset    = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    bubble();
    tick();
    tick();

    // Reset state
    chk("rst_wb_valid", {63'h0, wb_valid}, 64'h0);
    chk("rst_dm_req",   {63'h0, dm_req},   64'h0);
    chk("rst_stall",    {63'h0, stall_M},  64'h0);
    chk("rst_bus_err",  {63'h0, bus_err},  64'h0);
    chk("rst_pcsrc",    {63'h0, PCSrc_M},  64'h0);
    reset = 1'b1;
    tick();

    // LDUR 0x10, ack in first REQ cycle
    drive_ex(1, 1, 0, 0, 1, 1, 5'd1, 64'h0, 64'h10, 64'h0, 0);
    tick();
    chk("ld_stall_e1", {63'h0, stall_M}, 64'h1);
    chk("ld_req_e1",   {63'h0, dm_req},  64'h0);
    bubble();
    tick();
    chk("ld_req_e2",   {63'h0, dm_req},  64'h1);
    chk("ld_addr",     dm_addr,          64'h10);
    chk("ld_we",       {63'h0, dm_we},   64'h0);
    chk("ld_stall_e2", {63'h0, stall_M}, 64'h1);
    dm_ack   = 1'b1;
    dm_rdata = 64'hDEAD_BEEF;
    tick();
    dm_ack   = 1'b0;
    dm_rdata = 64'h0;
    chk("ld_stall_e3", {63'h0, stall_M},  64'h0);
    chk("ld_req_e3",   {63'h0, dm_req},   64'h0);
    chk("ld_wbv_e3",   {63'h0, wb_valid}, 64'h0);
    tick();
    chk("ld_wbv_e4",   {63'h0, wb_valid},    64'h1);
    chk("ld_rdata",    wb_readData,          64'hDEAD_BEEF);
    chk("ld_rd",       {59'h0, wb_rd},       64'd1);
    chk("ld_m2r",      {63'h0, wb_memToReg}, 64'h1);
    tick();
    chk("ld_wbv_e5",   {63'h0, wb_valid},    64'h0);

    // STUR 0x20 <- 0x55, ack delayed 3 cycles
    drive_ex(1, 0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h20, 64'h55, 0);
    tick();
    chk("st_stall_e1", {63'h0, stall_M}, 64'h1);
    chk("st_req_e1",   {63'h0, dm_req},  64'h0);
    bubble();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("st_req",   {63'h0, dm_req},  64'h1);
      chk("st_we",    {63'h0, dm_we},   64'h1);
      chk("st_addr",  dm_addr,          64'h20);
      chk("st_wdata", dm_wdata,         64'h55);
      chk("st_stall", {63'h0, stall_M}, 64'h1);
      if (k == 4) dm_ack = 1'b1;
    end
    tick();
    dm_ack = 1'b0;
    chk("st_stall_done", {63'h0, stall_M}, 64'h0);
    chk("st_req_done",   {63'h0, dm_req},  64'h0);
    tick();
    chk("st_wbv",        {63'h0, wb_valid},    64'h1);
    chk("st_wb_rw",      {63'h0, wb_regWrite}, 64'h0);

    // CBZ taken then not taken
    drive_ex(1, 0, 0, 1, 0, 0, 5'd0, 64'h400, 64'h0, 64'h0, 1);
    tick();
    chk("cbz_pcsrc",  {63'h0, PCSrc_M}, 64'h1);
    chk("cbz_target", PCBranch_M,       64'h400);
    chk("cbz_stall",  {63'h0, stall_M}, 64'h0);
    drive_ex(1, 0, 0, 1, 0, 0, 5'd0, 64'h800, 64'h0, 64'h0, 0);
    tick();
    chk("cbnz_pcsrc",  {63'h0, PCSrc_M},  64'h0);
    chk("cbnz_target", PCBranch_M,        64'h800);
    chk("cbz_wbv",     {63'h0, wb_valid}, 64'h1);
    bubble();
    tick();
    chk("bub_pcsrc",   {63'h0, PCSrc_M},  64'h0);

    // LDUR, LDUR, ADD back to back with ack held high
    dm_ack   = 1'b1;
    dm_rdata = 64'h1111;
    drive_ex(1, 1, 0, 0, 1, 1, 5'd2, 64'h0, 64'h30, 64'h0, 0);
    tick();
    chk("b2b_wbv_e1", {63'h0, wb_valid}, 64'h0);
    drive_ex(1, 1, 0, 0, 1, 1, 5'd3, 64'h0, 64'h38, 64'h0, 0);
    tick();
    chk("b2b_wbv_e2", {63'h0, wb_valid}, 64'h0);
    chk("b2b_addr_a", dm_addr,           64'h30);
    tick();
    chk("b2b_wbv_e3", {63'h0, wb_valid}, 64'h0);
    chk("b2b_stl_e3", {63'h0, stall_M},  64'h0);
    tick();
    chk("b2b_wbv_e4", {63'h0, wb_valid}, 64'h1);
    chk("b2b_rd_a",   {59'h0, wb_rd},    64'd2);
    chk("b2b_data_a", wb_readData,       64'h1111);
    chk("b2b_stl_e4", {63'h0, stall_M},  64'h1);
    dm_rdata = 64'h2222;
    drive_ex(1, 0, 0, 0, 1, 0, 5'd4, 64'h0, 64'h77, 64'h0, 0);
    tick();
    chk("b2b_wbv_e5", {63'h0, wb_valid}, 64'h0);
    chk("b2b_addr_b", dm_addr,           64'h38);
    tick();
    chk("b2b_wbv_e6", {63'h0, wb_valid}, 64'h0);
    tick();
    chk("b2b_wbv_e7", {63'h0, wb_valid}, 64'h1);
    chk("b2b_rd_b",   {59'h0, wb_rd},    64'd3);
    chk("b2b_data_b", wb_readData,       64'h2222);
    bubble();
    tick();
    chk("b2b_wbv_e8", {63'h0, wb_valid},    64'h1);
    chk("b2b_rd_add", {59'h0, wb_rd},       64'd4);
    chk("b2b_alu",    wb_aluResult,         64'h77);
    chk("b2b_m2r",    {63'h0, wb_memToReg}, 64'h0);
    chk("b2b_stl_e8", {63'h0, stall_M},     64'h0);
    tick();
    chk("b2b_wbv_e9", {63'h0, wb_valid},    64'h0);
    dm_ack   = 1'b0;
    dm_rdata = 64'h0;

    // Reset asserted during REQ
    drive_ex(1, 0, 0, 0, 1, 0, 5'd5, 64'h0, 64'h99, 64'h0, 0);
    tick();
    drive_ex(1, 1, 0, 0, 1, 1, 5'd6, 64'h0, 64'h40, 64'h0, 0);
    tick();
    chk("rq_wbv_add", {63'h0, wb_valid}, 64'h1);
    chk("rq_rd_add",  {59'h0, wb_rd},    64'd5);
    tick();
    chk("rq_req",     {63'h0, dm_req},   64'h1);
    chk("rq_rd_hold", {59'h0, wb_rd},    64'd5);
    #1 reset = 1'b0;
    #1;
    chk("rq_req_rst",   {63'h0, dm_req},      64'h0);
    chk("rq_stall_rst", {63'h0, stall_M},     64'h0);
    chk("rq_wbv_rst",   {63'h0, wb_valid},    64'h0);
    chk("rq_wbrd_rst",  {59'h0, wb_rd},       64'd0);
    chk("rq_alu_rst",   wb_aluResult,         64'h0);
    chk("rq_rw_rst",    {63'h0, wb_regWrite}, 64'h0);
    bubble();
    tick();
    reset    = 1'b1;
    dm_ack   = 1'b1;
    dm_rdata = 64'hBAD;
    tick();
    tick();
    chk("rq_late_req",  {63'h0, dm_req},   64'h0);
    chk("rq_late_wbv",  {63'h0, wb_valid}, 64'h0);
    chk("rq_late_stl",  {63'h0, stall_M},  64'h0);
    chk("rq_late_data", wb_readData,       64'h0);
    dm_ack   = 1'b0;
    dm_rdata = 64'h0;

    // Timeout with TIMEOUT=4 and no ack
    drive_ex(1, 1, 0, 0, 1, 1, 5'd7, 64'h0, 64'h50, 64'h0, 0);
    tick();
    chk("to_stall_e1", {63'h0, stall_M}, 64'h1);
    chk("to_req_e1",   {63'h0, dm_req},  64'h0);
    bubble();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("to_req",     {63'h0, dm_req},  64'h1);
      chk("to_err_pre", {63'h0, bus_err}, 64'h0);
    end
    tick();
    chk("to_err",      {63'h0, bus_err}, 64'h1);
    chk("to_req_err",  {63'h0, dm_req},  64'h0);
    chk("to_stall",    {63'h0, stall_M}, 64'h1);
    repeat (3) tick();
    chk("to_stuck_stall", {63'h0, stall_M},  64'h1);
    chk("to_stuck_err",   {63'h0, bus_err},  64'h1);
    chk("to_stuck_wbv",   {63'h0, wb_valid}, 64'h0);
    #1 reset = 1'b0;
    #1;
    chk("to_rst_err",   {63'h0, bus_err}, 64'h0);
    chk("to_rst_stall", {63'h0, stall_M}, 64'h0);
    chk("to_rst_req",   {63'h0, dm_req},  64'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("to_post_stall", {63'h0, stall_M}, 64'h0);
    chk("to_post_err",   {63'h0, bus_err}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
